mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit: consumes the EX/MEM pipeline-register outputs and
//  drives a request/acknowledge data-memory bus. Stalls upstream while an access
//  is pending, then presents one registered result beat to the MEM/WB register.
//  Non-memory instructions pass through with a fixed 1-cycle latency.
// PARAMETERS
//  LOAD_SEL  2'b01  in_WDSel value marking a load (write-back from memory)
//  TIMEOUT   16     max BUSY cycles waiting for mem_ack before abort (>=1)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  in_running   in   1   EX/MEM valid instruction
//  in_WEn       in   1   store enable
//  in_RFWr      in   1   register-file write enable
//  in_WDSel     in   2   write-back select (LOAD_SEL = load)
//  in_pc4       in   32  PC+4
//  in_C         in   32  ALU result / memory byte address
//  in_rD2       in   32  store data
//  in_wR        in   32  destination register
//  in_ext       in   32  immediate
//  stall        out  1   hold EX/MEM and earlier stages
//  mem_req      out  1   bus request, held until acked
//  mem_we       out  1   1 = write, 0 = read
//  mem_addr     out  32  word-aligned address
//  mem_wdata    out  32  store data
//  mem_ack      in   1   access complete; mem_rdata valid same cycle for reads
//  mem_rdata    in   32  read data
//  out_running  out  1   MEM/WB valid
//  out_RFWr / out_WDSel / out_pc4 / out_C / out_wR / out_ext  out  1/2/32/32/32/32
//  out_rdata    out  32  load data (0 for non-loads)
//  err_timeout  out  1   sticky, set on bus timeout, cleared only by rst
//  err_misalign out  1   1-cycle pulse on misaligned access
// BEHAVIOUR
//  - Reset: every output 0 on the rst edge; state IDLE; timeout counter 0.
//    Reset mid-access drops mem_req on that edge; later/outstanding acks ignored.
//  - mem_op = in_running & (in_WEn | in_WDSel==LOAD_SEL). Store wins if both set.
//  - stall (combinational) = (IDLE & mem_op & in_C[1:0]==0) | BUSY.
//  - IDLE, no mem_op: at each edge outputs <= inputs, out_rdata<=0,
//    out_running<=in_running. Latency 1.
//  - IDLE, mem_op, in_C[1:0]!=0: no bus request; outputs register as pass-through
//    with out_RFWr forced 0; err_misalign=1 for that cycle; stall stays 0.
//  - IDLE, mem_op aligned: edge -> BUSY; mem_req<=1, mem_we<=in_WEn,
//    mem_addr<=in_C, mem_wdata<=in_rD2; out_running<=0. Sidebands latched.
//  - BUSY: req/we/addr/wdata stable until ack. Counter increments per BUSY cycle.
//    ack sampled 1 -> edge: mem_req<=0, out_* <= latched sidebands,
//    out_rdata<=mem_we?0:mem_rdata, out_running<=1, -> DONE.
//    Counter reaches TIMEOUT with no ack -> mem_req<=0, err_timeout<=1,
//    result emitted as above with out_rdata=0, out_RFWr=0, -> DONE.
//  - DONE: stall=0 (upstream advances at this edge); edge -> IDLE,
//    out_running<=0; inputs this cycle are the retiring instruction and ignored.
//  - Min memory latency: req cycle after issue; ack in 1st BUSY cycle gives
//    stall high 2 cycles, out_running high in DONE cycle.
//  - mem_ack in IDLE/DONE ignored. Only one outstanding access ever.
// TESTING
//  1 ALU op C=0x10,RFWr=1,WDSel=0 -> next cycle out_running=1,out_C=0x10,stall=0.
//  2 load C=0x100, ack after 3 BUSY cycles, rdata=0xDEADBEEF -> req held 3 cycles
//    addr 0x100 we=0; stall 4 cycles; out_rdata=0xDEADBEEF,out_running=1 once.
//  3 store C=0x204,rD2=0x1234, ack 1st cycle -> we=1,wdata=0x1234,out_rdata=0.
//  4 load, no ack, TIMEOUT=16 -> req drops after 16 cycles, err_timeout=1 sticky,
//    out_RFWr=0.
//  5 load C=0x102 -> no mem_req, err_misalign pulse, out_RFWr=0, stall=0.
//  6 rst asserted in 2nd BUSY cycle, ack next cycle -> mem_req=0, outputs 0, ack
//    ignored, IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM instructions into req/ack data-memory accesses and registers one MEM/WB beat.
// Latency: non-memory ops 1 cycle; memory ops issue cycle + BUSY cycles until ack/timeout + 1 DONE cycle.
// Backpressure: stall holds upstream while an aligned access is issuing or outstanding; bus side waits on mem_ack.
module mem_stage_lsu #(
    parameter logic [1:0] LOAD_SEL = 2'b01,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_running,
    input  logic        in_WEn,
    input  logic        in_RFWr,
    input  logic [1:0]  in_WDSel,
    input  logic [31:0] in_pc4,
    input  logic [31:0] in_C,
    input  logic [31:0] in_rD2,
    input  logic [31:0] in_wR,
    input  logic [31:0] in_ext,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_running,
    output logic        out_RFWr,
    output logic [1:0]  out_WDSel,
    output logic [31:0] out_pc4,
    output logic [31:0] out_C,
    output logic [31:0] out_wR,
    output logic [31:0] out_ext,
    output logic [31:0] out_rdata,
    output logic        err_timeout,
    output logic        err_misalign
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    // Sidebands of the instruction that owns the outstanding access
    logic          lat_RFWr_q, lat_RFWr_d;
    logic [1:0]    lat_WDSel_q, lat_WDSel_d;
    logic [31:0]   lat_pc4_q, lat_pc4_d;
    logic [31:0]   lat_C_q, lat_C_d;
    logic [31:0]   lat_wR_q, lat_wR_d;
    logic [31:0]   lat_ext_q, lat_ext_d;

    logic          out_running_q, out_running_d;
    logic          out_RFWr_q, out_RFWr_d;
    logic [1:0]    out_WDSel_q, out_WDSel_d;
    logic [31:0]   out_pc4_q, out_pc4_d;
    logic [31:0]   out_C_q, out_C_d;
    logic [31:0]   out_wR_q, out_wR_d;
    logic [31:0]   out_ext_q, out_ext_d;
    logic [31:0]   out_rdata_q, out_rdata_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_misalign_q, err_misalign_d;

    logic          mem_op;
    logic          aligned;

    // Decode the incoming instruction and derive the upstream hold
    always_comb begin
        mem_op  = in_running & (in_WEn | (in_WDSel == LOAD_SEL));
        aligned = (in_C[1:0] == 2'b00);
        stall   = ((state_q == S_IDLE) & mem_op & aligned) | (state_q == S_BUSY);
    end

    // Next-state and next-output computation for the IDLE/BUSY/DONE access sequence
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cnt_inc        = cnt_q + CW'(1);
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        lat_RFWr_d     = lat_RFWr_q;
        lat_WDSel_d    = lat_WDSel_q;
        lat_pc4_d      = lat_pc4_q;
        lat_C_d        = lat_C_q;
        lat_wR_d       = lat_wR_q;
        lat_ext_d      = lat_ext_q;
        out_running_d  = out_running_q;
        out_RFWr_d     = out_RFWr_q;
        out_WDSel_d    = out_WDSel_q;
        out_pc4_d      = out_pc4_q;
        out_C_d        = out_C_q;
        out_wR_d       = out_wR_q;
        out_ext_d      = out_ext_q;
        out_rdata_d    = out_rdata_q;
        err_timeout_d  = err_timeout_q;
        err_misalign_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op && aligned) begin
                    // Issue: a store wins over a load when both are flagged
                    state_d       = S_BUSY;
                    cnt_d         = '0;
                    mem_req_d     = 1'b1;
                    mem_we_d      = in_WEn;
                    mem_addr_d    = in_C;
                    mem_wdata_d   = in_rD2;
                    out_running_d = 1'b0;
                    lat_RFWr_d    = in_RFWr;
                    lat_WDSel_d   = in_WDSel;
                    lat_pc4_d     = in_pc4;
                    lat_C_d       = in_C;
                    lat_wR_d      = in_wR;
                    lat_ext_d     = in_ext;
                end else begin
                    // Pass-through; a misaligned access is squashed to a no-write beat
                    out_running_d = in_running;
                    out_RFWr_d    = in_RFWr & ~mem_op;
                    out_WDSel_d   = in_WDSel;
                    out_pc4_d     = in_pc4;
                    out_C_d       = in_C;
                    out_wR_d      = in_wR;
                    out_ext_d     = in_ext;
                    out_rdata_d   = '0;
                    err_misalign_d = mem_op;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (mem_ack || (cnt_inc == CW'(TIMEOUT))) begin
                    state_d       = S_DONE;
                    mem_req_d     = 1'b0;
                    out_running_d = 1'b1;
                    out_WDSel_d   = lat_WDSel_q;
                    out_pc4_d     = lat_pc4_q;
                    out_C_d       = lat_C_q;
                    out_wR_d      = lat_wR_q;
                    out_ext_d     = lat_ext_q;
                    if (mem_ack) begin
                        out_RFWr_d  = lat_RFWr_q;
                        out_rdata_d = mem_we_q ? 32'd0 : mem_rdata;
                    end else begin
                        // Abandoned access must not write the register file
                        out_RFWr_d    = 1'b0;
                        out_rdata_d   = '0;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Upstream advances this cycle; its inputs are the retiring instruction
                state_d       = S_IDLE;
                out_running_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset clearing every output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            lat_RFWr_q     <= 1'b0;
            lat_WDSel_q    <= '0;
            lat_pc4_q      <= '0;
            lat_C_q        <= '0;
            lat_wR_q       <= '0;
            lat_ext_q      <= '0;
            out_running_q  <= 1'b0;
            out_RFWr_q     <= 1'b0;
            out_WDSel_q    <= '0;
            out_pc4_q      <= '0;
            out_C_q        <= '0;
            out_wR_q       <= '0;
            out_ext_q      <= '0;
            out_rdata_q    <= '0;
            err_timeout_q  <= 1'b0;
            err_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            lat_RFWr_q     <= lat_RFWr_d;
            lat_WDSel_q    <= lat_WDSel_d;
            lat_pc4_q      <= lat_pc4_d;
            lat_C_q        <= lat_C_d;
            lat_wR_q       <= lat_wR_d;
            lat_ext_q      <= lat_ext_d;
            out_running_q  <= out_running_d;
            out_RFWr_q     <= out_RFWr_d;
            out_WDSel_q    <= out_WDSel_d;
            out_pc4_q      <= out_pc4_d;
            out_C_q        <= out_C_d;
            out_wR_q       <= out_wR_d;
            out_ext_q      <= out_ext_d;
            out_rdata_q    <= out_rdata_d;
            err_timeout_q  <= err_timeout_d;
            err_misalign_q <= err_misalign_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign out_running  = out_running_q;
    assign out_RFWr     = out_RFWr_q;
    assign out_WDSel    = out_WDSel_q;
    assign out_pc4      = out_pc4_q;
    assign out_C        = out_C_q;
    assign out_wR       = out_wR_q;
    assign out_ext      = out_ext_q;
    assign out_rdata    = out_rdata_q;
    assign err_timeout  = err_timeout_q;
    assign err_misalign = err_misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: scripted scenarios with a result scoreboard.
// Inputs driven 1 time unit after posedge; outputs sampled after the edge or at negedge.
// Memory acks are scripted per scenario; every wait is bounded.
module tb_mem_stage_lsu;

    localparam logic [1:0] LOAD_SEL = 2'b01;
    localparam int         TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_running, in_WEn, in_RFWr;
    logic [1:0]  in_WDSel;
    logic [31:0] in_pc4, in_C, in_rD2, in_wR, in_ext;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_running, out_RFWr;
    logic [1:0]  out_WDSel;
    logic [31:0] out_pc4, out_C, out_wR, out_ext, out_rdata;
    logic        err_timeout, err_misalign;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        rfwr;
        logic [1:0]  wdsel;
        logic [31:0] pc4;
        logic [31:0] c;
        logic [31:0] wr;
        logic [31:0] ext;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mem_stage_lsu #(.LOAD_SEL(LOAD_SEL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_running(in_running), .in_WEn(in_WEn), .in_RFWr(in_RFWr), .in_WDSel(in_WDSel),
        .in_pc4(in_pc4), .in_C(in_C), .in_rD2(in_rD2), .in_wR(in_wR), .in_ext(in_ext),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_running(out_running), .out_RFWr(out_RFWr), .out_WDSel(out_WDSel),
        .out_pc4(out_pc4), .out_C(out_C), .out_wR(out_wR), .out_ext(out_ext),
        .out_rdata(out_rdata), .err_timeout(err_timeout), .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid MEM/WB beat must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && out_running) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected_beat: out_running=1 out_C=%h, expected no beat", out_C);
            end else begin
                mon_e = sb.pop_front();
                checks++; if (out_RFWr !== mon_e.rfwr) $display("FAIL sb_RFWr: got %b want %b", out_RFWr, mon_e.rfwr); else passes++;
                checks++; if (out_WDSel !== mon_e.wdsel) $display("FAIL sb_WDSel: got %b want %b", out_WDSel, mon_e.wdsel); else passes++;
                checks++; if (out_pc4 !== mon_e.pc4) $display("FAIL sb_pc4: got %h want %h", out_pc4, mon_e.pc4); else passes++;
                checks++; if (out_C !== mon_e.c) $display("FAIL sb_C: got %h want %h", out_C, mon_e.c); else passes++;
                checks++; if (out_wR !== mon_e.wr) $display("FAIL sb_wR: got %h want %h", out_wR, mon_e.wr); else passes++;
                checks++; if (out_ext !== mon_e.ext) $display("FAIL sb_ext: got %h want %h", out_ext, mon_e.ext); else passes++;
                checks++; if (out_rdata !== mon_e.rdata) $display("FAIL sb_rdata: got %h want %h", out_rdata, mon_e.rdata); else passes++;
            end
        end
    end

    task automatic drive(input logic run, input logic wen, input logic rfwr, input logic [1:0] wdsel,
                         input logic [31:0] pc4, input logic [31:0] c, input logic [31:0] rd2,
                         input logic [31:0] wr, input logic [31:0] ext);
        in_running = run; in_WEn = wen; in_RFWr = rfwr; in_WDSel = wdsel;
        in_pc4 = pc4; in_C = c; in_rD2 = rd2; in_wR = wr; in_ext = ext;
    endtask

    task automatic push(input logic rfwr, input logic [1:0] wdsel, input logic [31:0] pc4,
                        input logic [31:0] c, input logic [31:0] wr, input logic [31:0] ext,
                        input logic [31:0] rdata);
        exp_t e;
        e.rfwr = rfwr; e.wdsel = wdsel; e.pc4 = pc4; e.c = c; e.wr = wr; e.ext = ext; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h4, 32'h88, 32'h0, 32'h3, 32'h9);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_running !== 1'b0) $display("FAIL reset_out_running: got %b want 0", out_running); else passes++;
        checks++; if (out_RFWr !== 1'b0) $display("FAIL reset_out_RFWr: got %b want 0", out_RFWr); else passes++;
        checks++; if (out_C !== 32'h0) $display("FAIL reset_out_C: got %h want 0", out_C); else passes++;
        checks++; if (out_rdata !== 32'h0) $display("FAIL reset_out_rdata: got %h want 0", out_rdata); else passes++;
        checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passes++;
        checks++; if (err_timeout !== 1'b0 || err_misalign !== 1'b0) $display("FAIL reset_err: got %b%b want 00", err_timeout, err_misalign); else passes++;
        rst = 1'b0; mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h104, 32'h10, 32'h0, 32'd5, 32'd7);
        push(1'b1, 2'b00, 32'h104, 32'h10, 32'd5, 32'd7, 32'h0);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL alu_stall_issue: got %b want 0", stall); else passes++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (out_running !== 1'b1) $display("FAIL alu_out_running: got %b want 1", out_running); else passes++;
        checks++; if (out_C !== 32'h10) $display("FAIL alu_out_C: got %h want 10", out_C); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else passes++;
        @(posedge clk); #1;
        checks++; if (out_running !== 1'b0) $display("FAIL alu_out_running_drop: got %b want 0", out_running); else passes++;
    endtask

    // Consecutive non-memory ops with a bubble and a stray ack on the bus
    task automatic test_back_to_back();
        logic [3:0] runs;
        logic [1:0] sel;
        runs = 4'b1011;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            sel = (i == 3) ? 2'b10 : 2'b00;
            drive(runs[i], 1'b0, 1'(i % 2), sel, 32'h200 + 32'(i * 4), 32'h40 + 32'(i), 32'h0, 32'(i + 1), 32'(i * 3));
            if (runs[i]) push(1'(i % 2), sel, 32'h200 + 32'(i * 4), 32'h40 + 32'(i), 32'(i + 1), 32'(i * 3), 32'h0);
            @(posedge clk); #1;
            checks++; if (mem_req !== 1'b0) $display("FAIL b2b_mem_req[%0d]: got %b want 0", i, mem_req); else passes++;
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one aligned access; ack_at = BUSY cycle carrying the ack, 0 = never
    task automatic run_mem(input string nm, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata, input int want_req, input int want_stall);
        int req_cycles, stall_cycles;
        logic done;
        req_cycles = 0; stall_cycles = 0; done = 1'b0;
        drive(1'b1, we, 1'b1, we ? 2'b00 : LOAD_SEL, addr + 32'h4, addr, wdata, 32'd12, 32'h77);
        push((ack_at == 0) ? 1'b0 : 1'b1, we ? 2'b00 : LOAD_SEL, addr + 32'h4, addr, 32'd12, 32'h77,
             (ack_at == 0 || we) ? 32'h0 : rdata);
        #1;
        if (stall) stall_cycles++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_req) begin done = 1'b1; break; end
            req_cycles++;
            checks++;
            if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata)
                $display("FAIL %s_bus: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h", nm, mem_addr, mem_we, mem_wdata, addr, we, wdata);
            else passes++;
            if (k == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
            #1;
            if (stall) stall_cycles++;
        end
        checks++; if (!done) $display("FAIL %s_req_drop: mem_req still 1 after 40 cycles, want drop", nm); else passes++;
        checks++; if (req_cycles != want_req) $display("FAIL %s_req_cycles: got %0d want %0d", nm, req_cycles, want_req); else passes++;
        checks++; if (stall_cycles != want_stall) $display("FAIL %s_stall_cycles: got %0d want %0d", nm, stall_cycles, want_stall); else passes++;
        checks++; if (stall !== 1'b0 || out_running !== 1'b1) $display("FAIL %s_done: got stall=%b out_running=%b want 0/1", nm, stall, out_running); else passes++;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++; if (out_running !== 1'b0 || mem_req !== 1'b0) $display("FAIL %s_idle: got out_running=%b mem_req=%b want 0/0", nm, out_running, mem_req); else passes++;
    endtask

    task automatic test_load();
        run_mem("load", 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 3, 4);
        checks++; if (err_timeout !== 1'b0) $display("FAIL load_err_timeout: got %b want 0", err_timeout); else passes++;
    endtask

    task automatic test_store();
        run_mem("store", 1'b1, 32'h204, 32'h1234, 1, 32'hCAFE_F00D, 1, 2);
    endtask

    task automatic test_timeout();
        run_mem("timeout", 1'b0, 32'h300, 32'h0, 0, 32'h0, TIMEOUT, TIMEOUT + 1);
        checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_err: got %b want 1", err_timeout); else passes++;
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 1'b1, LOAD_SEL, 32'h50, 32'h102, 32'h0, 32'd9, 32'h1);
        push(1'b0, LOAD_SEL, 32'h50, 32'h102, 32'd9, 32'h1, 32'h0);
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL misalign_stall: got %b want 0", stall); else passes++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (err_misalign !== 1'b1) $display("FAIL misalign_pulse: got %b want 1", err_misalign); else passes++;
        checks++; if (mem_req !== 1'b0) $display("FAIL misalign_mem_req: got %b want 0", mem_req); else passes++;
        checks++; if (out_RFWr !== 1'b0) $display("FAIL misalign_RFWr: got %b want 0", out_RFWr); else passes++;
        @(posedge clk); #1;
        checks++; if (err_misalign !== 1'b0) $display("FAIL misalign_pulse_end: got %b want 0", err_misalign); else passes++;
        checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err_timeout); else passes++;
    endtask

    task automatic test_reset_mid_access();
        drive(1'b1, 1'b0, 1'b1, LOAD_SEL, 32'h404, 32'h400, 32'h0, 32'd2, 32'h5);
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) $display("FAIL rstmid_req: got %b want 1", mem_req); else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req_drop: got %b want 0", mem_req); else passes++;
        checks++; if (out_running !== 1'b0 || out_rdata !== 32'h0 || out_C !== 32'h0) $display("FAIL rstmid_outputs: got run=%b rdata=%h C=%h want 0", out_running, out_rdata, out_C); else passes++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL rstmid_err_timeout: got %b want 0", err_timeout); else passes++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b0 || out_running !== 1'b0 || out_rdata !== 32'h0 || stall !== 1'b0)
                $display("FAIL rstmid_idle[%0d]: got req=%b run=%b rdata=%h stall=%b want 0", i, mem_req, out_running, out_rdata, stall);
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_misalign();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sb.size() != 0) $display("FAIL sb_leftover: %0d expected beats never seen, want 0", sb.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
